pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Fetch-side program counter plus branch resolver that consumes the execute-stage ALU flags (fZero, fSign, fCarry).
- Holds the architectural flag register and evaluates all KGP-RISC branch forms.
- Drives the next PC, the link write for bl, and a one-cycle flush bubble after every taken branch.

Parameters:
PC_WIDTH, 32, width of PC and all address/target values
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per sequential instruction

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  advance enable; 0 = stall, all state held
instr_valid  input  1  current instruction is real (not a bubble)
br_op  input  4  branch code (encoding below)
flag_we  input  1  current ALU instruction updates flags
fZero  input  1  ALU zero flag, current cycle
fSign  input  1  ALU sign flag, current cycle
fCarry  input  1  ALU carry flag, current cycle
rs_val  input  32  register rs value (br target, bltz/bz/bnz test)
offset  input  32  sign-extended byte offset for label branches
pc  output  PC_WIDTH  current PC, registered
next_pc  output  PC_WIDTH  combinational PC for the next edge
taken  output  1  registered; 1 for the cycle after a taken branch
flush  output  1  registered; 1 while in FLUSH state
link_we  output  1  combinational; write ra this cycle (bl)
link_data  output  32  pc + PC_STEP
z_flag, s_flag, c_flag  output  1 each  registered flag register

Behaviour:
- Reset (async, any time, including mid-FLUSH): pc=RESET_PC, z/s/c_flag=0, taken=0, flush=0, state=RUN. Released state starts fetching at RESET_PC.
- br_op encoding:
  - 0000 none; 0001 b; 0010 br; 0011 bltz; 0100 bz; 0101 bnz; 0110 bl; 0111 bcy; 1000 bncy.
  - 1001-1111 are treated as none.
- Targets and conditions:
  - Label target = pc + PC_STEP + offset, modulo 2^PC_WIDTH.
  - br target = rs_val.
  - b, br, bl: always taken.
  - bltz: taken when rs_val[31]=1. bz: taken when rs_val==0. bnz: taken when rs_val!=0.
  - bcy: taken when c_flag=1. bncy: taken when c_flag=0. Both use the registered flag, never the same-cycle fCarry.
- Qualified cycle: q = en & instr_valid & (state==RUN).
- next_pc:
  - Equals the target when q and the branch is taken.
  - Otherwise equals pc + PC_STEP when en=1.
  - Otherwise equals pc.
  - Sequential wrap from 32'hFFFF_FFFC yields 0.
- Edge with en=1: pc<=next_pc; taken<=q&hit; state<=FLUSH if q&hit, else RUN.
- In FLUSH (one cycle):
  - flush=1; the instruction present is a wrong-path bubble.
  - Branches are ignored, flags are not written, link_we=0.
  - pc advances by PC_STEP.
  - Next state is RUN.
- Edge with en=0: pc, flags, state, taken and flush are all held. A stall inside FLUSH extends FLUSH.
- Flags: on an edge with q&flag_we, z/s/c_flag<=fZero/fSign/fCarry; otherwise held.
- Simultaneous flag_we and bcy/bncy in the same cycle: the branch evaluates the old c_flag; the new value is visible from the next cycle.
- link_we = q & (br_op==0110); link_data = pc + PC_STEP. The register file captures them on the same edge.
- Latency:
  - Branch decision is combinational into next_pc; target appears on pc one edge later.
  - Exactly one bubble per taken branch; not-taken branches cost nothing.
- FSM states: RUN, FLUSH. No other states; an illegal state encoding recovers to RUN.

Test Plan:
- Reset: assert rst mid-FLUSH -> pc=0, flush=0, taken=0, flags=000 immediately (without waiting for a clock edge). After release with en=1, instr_valid=1, br_op=0: pc sequence 0,4,8.
- Label branch: pc=8, br_op=0001, offset=-8 -> next_pc=4, pc=4 next edge, taken=1 and flush=1 for one cycle.
  - Any br_op=0001 presented during that FLUSH cycle is ignored; pc=8 after FLUSH.
- bl/br: pc=16, br_op=0110, offset=32 -> link_we=1 and link_data=20 that cycle, pc=52.
  - Then br_op=0010 with rs_val=20 (after the flush) -> pc=20.
- Flag capture: ALU 12+10 with flag_we=1 and fZero=0, fSign=0, fCarry=0, while bcy is presented in the same cycle -> uses the old c_flag=1 (set earlier) and is taken.
  - Next cycle bcy -> c_flag=0, not taken, pc+4.
- Register tests:
  - bltz with rs_val=32'h8000_0000 -> taken.
  - bz with rs_val=0 -> taken.
  - bnz with rs_val=0 -> not taken.
  - br_op=1011 (unused code) -> not taken.
- Stall and wrap:
  - en=0 for 3 cycles during FLUSH -> pc, flush and flags frozen; FLUSH ends one enabled cycle later.
  - pc=32'hFFFF_FFFC with no branch -> pc=0.

Source files
------------

// File: rtl/pc_branch_unit_if.sv
// Bundle between the execute stage and the fetch-side PC/branch unit.
// The master side drives instruction/ALU information; the slave side
// (the PC unit) returns the PC, branch status, link write and flags.
interface pc_branch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                en;
    logic                instr_valid;
    logic [3:0]          br_op;
    logic                flag_we;
    logic                fZero;
    logic                fSign;
    logic                fCarry;
    logic [31:0]         rs_val;
    logic [31:0]         offset;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic                taken;
    logic                flush;
    logic                link_we;
    logic [31:0]         link_data;
    logic                z_flag;
    logic                s_flag;
    logic                c_flag;

    modport master (
        output en, instr_valid, br_op, flag_we, fZero, fSign, fCarry, rs_val, offset,
        input  pc, next_pc, taken, flush, link_we, link_data, z_flag, s_flag, c_flag
    );

    modport slave (
        input  en, instr_valid, br_op, flag_we, fZero, fSign, fCarry, rs_val, offset,
        output pc, next_pc, taken, flush, link_we, link_data, z_flag, s_flag, c_flag
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Fetch-side program counter and KGP-RISC branch resolver.
// Holds the architectural flag register, resolves all branch forms in the
// same cycle, and inserts exactly one wrong-path bubble after a taken branch.
module pc_branch_unit #(
    parameter int          PC_WIDTH = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_branch_unit_if.slave bus
);

    localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] PC_START = PC_WIDTH'(RESET_PC);

    // One-hot style codes so a corrupted state register is detectable
    typedef enum logic [1:0] {
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                taken_q;
    logic                flush_q;
    logic                z_q;
    logic                s_q;
    logic                c_q;

    logic                qualified;
    logic                hit;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] next_pc_c;

    assign qualified = bus.en & bus.instr_valid & (state == RUN);
    assign seq_pc    = pc_q + STEP;

    // Branch condition and target selection; conditional-carry forms use the
    // registered flag so a same-cycle flag write is seen only afterwards
    always_comb begin
        hit    = 1'b0;
        target = seq_pc + PC_WIDTH'(bus.offset);
        case (bus.br_op)
            4'b0001: hit = 1'b1;
            4'b0010: begin
                hit    = 1'b1;
                target = PC_WIDTH'(bus.rs_val);
            end
            4'b0011: hit = bus.rs_val[31];
            4'b0100: hit = (bus.rs_val == 32'd0);
            4'b0101: hit = (bus.rs_val != 32'd0);
            4'b0110: hit = 1'b1;
            4'b0111: hit = c_q;
            4'b1000: hit = ~c_q;
            default: hit = 1'b0;
        endcase
    end

    // Next-PC mux: taken target, sequential step, or hold on stall
    always_comb begin
        next_pc_c = pc_q;
        if (qualified && hit) begin
            next_pc_c = target;
        end else if (bus.en) begin
            next_pc_c = seq_pc;
        end
    end

    // PC, flags and RUN/FLUSH sequencing; everything freezes when en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pc_q    <= PC_START;
            taken_q <= 1'b0;
            flush_q <= 1'b0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            c_q     <= 1'b0;
        end else if (bus.en) begin
            pc_q    <= next_pc_c;
            taken_q <= qualified & hit;
            if (qualified && bus.flag_we) begin
                z_q <= bus.fZero;
                s_q <= bus.fSign;
                c_q <= bus.fCarry;
            end
            case (state)
                RUN: begin
                    if (qualified && hit) begin
                        state   <= FLUSH;
                        flush_q <= 1'b1;
                    end else begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
                default: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.next_pc   = next_pc_c;
    assign bus.taken     = taken_q;
    assign bus.flush     = flush_q;
    assign bus.link_we   = qualified & (bus.br_op == 4'b0110);
    assign bus.link_data = 32'(seq_pc);
    assign bus.z_flag    = z_q;
    assign bus.s_flag    = s_q;
    assign bus.c_flag    = c_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a stimulus process drives one
// instruction per cycle and queues the expected outputs from an abstract
// model; a monitor process pops and compares them mid-cycle.
module tb_pc_branch_unit;

    logic clk;
    logic rst;

    pc_branch_unit_if #(.PC_WIDTH(32)) bus ();

    pc_branch_unit #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] link_data;
        logic        taken;
        logic        flush;
        logic        link_we;
        logic        z;
        logic        s;
        logic        c;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Abstract model state: architectural PC, flags, and whether the
    // current cycle holds a wrong-path bubble
    logic [31:0] m_pc = 32'd0;
    logic        m_z = 1'b0, m_s = 1'b0, m_c = 1'b0;
    logic        m_bubble = 1'b0;
    logic        m_taken = 1'b0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst_v, input bit en_v, input bit iv_v,
                                 input logic [3:0] op, input bit fwe,
                                 input bit fz, input bit fs, input bit fc,
                                 input logic [31:0] rs, input logic [31:0] off);
        exp_t        e;
        logic [31:0] seq;
        logic [31:0] dest;
        bit          active;
        bit          tk;
        @(negedge clk);
        rst             = rst_v;
        bus.en          = en_v;
        bus.instr_valid = iv_v;
        bus.br_op       = op;
        bus.flag_we     = fwe;
        bus.fZero       = fz;
        bus.fSign       = fs;
        bus.fCarry      = fc;
        bus.rs_val      = rs;
        bus.offset      = off;
        if (rst_v) begin
            m_pc = 32'd0; m_z = 0; m_s = 0; m_c = 0; m_bubble = 0; m_taken = 0;
        end
        seq    = m_pc + 32'd4;
        active = en_v && iv_v && !m_bubble;
        case (op)
            4'd1, 4'd2, 4'd6: tk = 1;
            4'd3:             tk = rs[31];
            4'd4:             tk = (rs == 0);
            4'd5:             tk = (rs != 0);
            4'd7:             tk = m_c;
            4'd8:             tk = !m_c;
            default:          tk = 0;
        endcase
        dest        = (op == 4'd2) ? rs : seq + off;
        e.pc        = m_pc;
        e.taken     = m_taken;
        e.flush     = m_bubble;
        e.z         = m_z;
        e.s         = m_s;
        e.c         = m_c;
        e.next_pc   = (active && tk) ? dest : (en_v ? seq : m_pc);
        e.link_we   = active && (op == 4'd6);
        e.link_data = seq;
        sb.push_back(e);
        if (!rst_v && en_v) begin
            m_pc     = e.next_pc;
            m_taken  = active && tk;
            if (active && fwe) begin
                m_z = fz; m_s = fs; m_c = fc;
            end
            m_bubble = active && tk;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] off);
        applyStimulus(0, 1, 1, op, 0, 0, 0, 0, rs, off);
    endtask

    // Monitor: mid-cycle, compare the DUT against every queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("pc",        bus.pc,        e.pc);
                checkOutput("next_pc",   bus.next_pc,   e.next_pc);
                checkOutput("taken",     32'(bus.taken),   32'(e.taken));
                checkOutput("flush",     32'(bus.flush),   32'(e.flush));
                checkOutput("link_we",   32'(bus.link_we), 32'(e.link_we));
                if (e.link_we) checkOutput("link_data", bus.link_data, e.link_data);
                checkOutput("flags",     {29'd0, bus.z_flag, bus.s_flag, bus.c_flag},
                                         {29'd0, e.z, e.s, e.c});
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] rs;
        logic [31:0] off;
        rst = 1'b1;
        bus.en = 0; bus.instr_valid = 0; bus.br_op = 0; bus.flag_we = 0;
        bus.fZero = 0; bus.fSign = 0; bus.fCarry = 0; bus.rs_val = 0; bus.offset = 0;

        applyStimulus(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);
        // label branch back from 8 to 4, branch in the bubble is ignored
        run(4'd1, 0, 32'hFFFF_FFF8);
        run(4'd1, 0, 32'hFFFF_FFF8);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);
        // bl from 16, then br back to the link address
        run(4'd6, 0, 32'd32);
        run(4'd0, 0, 0);
        run(4'd2, 32'd20, 0);
        run(4'd0, 0, 0);
        // carry set, then bcy with a same-cycle flag write clearing it
        applyStimulus(0, 1, 1, 4'd0, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 4'd7, 1, 0, 0, 0, 0, 32'd16);
        run(4'd0, 0, 0);
        run(4'd7, 0, 32'd16);
        // register-tested forms and an unused code
        run(4'd3, 32'h8000_0000, 32'd8);
        run(4'd0, 0, 0);
        run(4'd4, 32'd0, 32'd12);
        run(4'd0, 0, 0);
        run(4'd5, 32'd0, 32'd12);
        run(4'd11, 0, 32'd12);
        // stall inside the bubble
        run(4'd1, 0, 32'd64);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'd1, 1, 1, 1, 1, 0, 32'd64);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);
        // reset asserted in the middle of a bubble
        run(4'd1, 0, 32'd100);
        applyStimulus(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);
        // wrap from the top of the address space
        run(4'd2, 32'hFFFF_FFF8, 0);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);
        run(4'd0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0:       rs = 32'd0;
                1:       rs = 32'h8000_0000 | $urandom;
                default: rs = $urandom;
            endcase
            off = 32'($urandom_range(0, 255)) * 32'd4;
            if ($urandom % 2 == 1) off = -off;
            applyStimulus(($urandom % 64) == 0, ($urandom % 5) != 0, ($urandom % 10) != 0,
                          4'($urandom % 16), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), rs, off);
        end

        @(negedge clk);
        #5;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
